conv_frame_sequencer: RTL and testbench

Controller that runs one full image through the conv+pool datapath per host request. On a start pulse it kicks the conv engine and streams IMG_W*IMG_H pixels from a synchronous image RAM, one per cycle. It writes every valid conv/pool result into a result RAM and reports completion, result count and error status to the host. It sits between the host/control logic and the conv datapath, replacing the hand-driven start/pixel sequence.

---
 rtl/conv_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: runs one image through the conv+pool datapath per
// host start. Streams IMG_W*IMG_H pixels from a synchronous image RAM,
// stores every conv/pool result in a result RAM and reports completion,
// result count and error status.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; all strobes low
//   KICK   | one cycle: conv_start pulse, first image read (addr 0)
//   STREAM | one image read per cycle, addr 1 .. N-1
//   DRAIN  | no reads; wait for conv_done or the timeout terminal count
//   DONE   | one cycle: done pulse, then back to IDLE
module conv_frame_sequencer #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int PIX_W     = 8,
  parameter int OUT_W     = 21,
  parameter int IADDR_W   = 10,
  parameter int RES_DEPTH = 169,
  parameter int RADDR_W   = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_overflow,
  output logic [RADDR_W:0]   result_count,
  output logic               img_re,
  output logic [IADDR_W-1:0] img_addr,
  input  logic [PIX_W-1:0]   img_rdata,
  output logic               conv_start,
  output logic [PIX_W-1:0]   conv_pixel,
  output logic               conv_pixel_valid,
  input  logic [OUT_W-1:0]   conv_out,
  input  logic               conv_out_valid,
  input  logic               conv_done,
  output logic               res_we,
  output logic [RADDR_W-1:0] res_addr,
  output logic [OUT_W-1:0]   res_wdata
);

  localparam int N     = IMG_W * IMG_H;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IADDR_W-1:0] LAST_ADDR = IADDR_W'(N - 1);
  localparam logic [RADDR_W:0]   RES_FULL  = (RADDR_W + 1)'(RES_DEPTH);
  localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic             done_seen;   // conv_done arrived before DRAIN
  logic [TMO_W-1:0] tmo_cnt;     // DRAIN timer, counts down to zero
  logic             capture_en;
  logic             tmo_hit;

  // The pixel path is a pure pass-through; validity is tracked by the
  // registered conv_pixel_valid one cycle behind img_re.
  assign conv_pixel = img_rdata;

  // Next-state decode; abort overrides everything outside IDLE.
  always_comb begin
    capture_en = (state == S_KICK) || (state == S_STREAM) || (state == S_DRAIN);
    tmo_hit    = (state == S_DRAIN) && !conv_done && !done_seen &&
                 (tmo_cnt == '0) && !abort;
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_KICK;
      S_KICK:   next_state = S_STREAM;
      S_STREAM: if (img_addr == LAST_ADDR) next_state = S_DRAIN;
      S_DRAIN:  if (conv_done || done_seen || (tmo_cnt == '0)) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  // State, registered strobes derived from the next state, and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      err_overflow     <= 1'b0;
      result_count     <= '0;
      img_re           <= 1'b0;
      img_addr         <= '0;
      conv_start       <= 1'b0;
      conv_pixel_valid <= 1'b0;
      res_we           <= 1'b0;
      res_addr         <= '0;
      res_wdata        <= '0;
      done_seen        <= 1'b0;
      tmo_cnt          <= '0;
    end else begin
      state            <= next_state;
      busy             <= (next_state != S_IDLE);
      done             <= (next_state == S_DONE);
      conv_start       <= (next_state == S_KICK);
      img_re           <= (next_state == S_KICK) || (next_state == S_STREAM);
      // A read issued on the abort edge still delivers its pixel.
      conv_pixel_valid <= img_re;

      if (next_state == S_KICK)
        img_addr <= '0;
      else if (next_state == S_STREAM)
        img_addr <= img_addr + IADDR_W'(1);

      if ((state == S_IDLE) && start) begin
        result_count <= '0;
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
        done_seen    <= 1'b0;
      end

      if (((state == S_KICK) || (state == S_STREAM)) && conv_done)
        done_seen <= 1'b1;

      if ((next_state == S_DRAIN) && (state != S_DRAIN))
        tmo_cnt <= TMO_LOAD;
      else if ((state == S_DRAIN) && (tmo_cnt != '0))
        tmo_cnt <= tmo_cnt - TMO_W'(1);

      if (tmo_hit)
        err_timeout <= 1'b1;

      res_we <= 1'b0;
      if (capture_en && conv_out_valid && !abort) begin
        if (result_count == RES_FULL) begin
          err_overflow <= 1'b1;
        end else begin
          res_we       <= 1'b1;
          res_addr     <= result_count[RADDR_W-1:0];
          res_wdata    <= conv_out;
          result_count <= result_count + (RADDR_W + 1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: drives whole frames through conv_frame_sequencer
// with a behavioural image RAM and a randomized conv-engine model, and checks
// the observed frame against what the frame rules predict.
module tb_conv_frame_sequencer;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int PIX_W     = 8;
  localparam int OUT_W     = 21;
  localparam int IADDR_W   = 10;
  localparam int RES_DEPTH = 169;
  localparam int RADDR_W   = 8;
  localparam int TIMEOUT   = 4096;
  localparam int N         = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               busy;
  logic               done;
  logic               err_timeout;
  logic               err_overflow;
  logic [RADDR_W:0]   result_count;
  logic               img_re;
  logic [IADDR_W-1:0] img_addr;
  logic [PIX_W-1:0]   img_rdata = '0;
  logic               conv_start;
  logic [PIX_W-1:0]   conv_pixel;
  logic               conv_pixel_valid;
  logic [OUT_W-1:0]   conv_out = '0;
  logic               conv_out_valid = 1'b0;
  logic               conv_done = 1'b0;
  logic               res_we;
  logic [RADDR_W-1:0] res_addr;
  logic [OUT_W-1:0]   res_wdata;

  conv_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .OUT_W(OUT_W),
    .IADDR_W(IADDR_W), .RES_DEPTH(RES_DEPTH), .RADDR_W(RADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overflow(err_overflow), .result_count(result_count),
    .img_re(img_re), .img_addr(img_addr), .img_rdata(img_rdata),
    .conv_start(conv_start), .conv_pixel(conv_pixel), .conv_pixel_valid(conv_pixel_valid),
    .conv_out(conv_out), .conv_out_valid(conv_out_valid), .conv_done(conv_done),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous image RAM model: data one cycle after the read enable.
  logic [PIX_W-1:0] mem [0:N-1];
  always @(posedge clk) if (img_re) img_rdata <= mem[img_addr];

  int n_vec = 0;
  int n_bad = 0;

  // Observations of the most recent frame.
  int cs_cnt, cs_idx, pv_cnt, pv_first, pv_last, pv_gap, pix_bad;
  int first_pix, last_pix, wr_cnt, wr_bad, last_waddr, done_cnt, done_idx;
  int last_re_idx, re_cnt, addr_bad, fall_idx, emitted, hung, cnt0, last_re_val;
  logic ovf0, tmo0;
  logic [OUT_W-1:0] exp_q [$];

  task automatic fill_mem(input bit ramp);
    for (int k = 0; k < N; k++) mem[k] = ramp ? PIX_W'(k) : PIX_W'($urandom);
  endtask

  function automatic int exp_count(input int n);
    return (n > RES_DEPTH) ? RES_DEPTH : n;
  endfunction

  // Pulses start, then runs the frame cycle by cycle until busy falls.
  // Sample index 0 is the cycle right after the start edge (KICK).
  // done_at/abort_at/start_at/rst_at name the sample at which that input is
  // driven for the following edge (-1 = never).
  task automatic run_frame(input int n_res, input int done_at, input int abort_at,
                           input int start_at, input int rst_at);
    cs_cnt = 0; cs_idx = -1; pv_cnt = 0; pv_first = -1; pv_last = -1; pv_gap = 0;
    pix_bad = 0; first_pix = -1; last_pix = -1; wr_cnt = 0; wr_bad = 0; last_waddr = -1;
    done_cnt = 0; done_idx = -1; last_re_idx = -1; re_cnt = 0; addr_bad = 0;
    fall_idx = -1; emitted = 0; hung = 1; last_re_val = -1;
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (i == 0) begin ovf0 = err_overflow; tmo0 = err_timeout; cnt0 = int'(result_count); end
      if (conv_start) begin cs_cnt++; cs_idx = i; end
      if (img_re) begin
        if (img_addr !== IADDR_W'(re_cnt)) addr_bad++;
        re_cnt++; last_re_idx = i;
      end
      if (conv_pixel_valid) begin
        if (pv_cnt > 0 && pv_last != i - 1) pv_gap++;
        if (pv_cnt == 0) begin pv_first = i; first_pix = int'(conv_pixel); end
        if (pv_cnt >= N || conv_pixel !== mem[pv_cnt]) pix_bad++;
        last_pix = int'(conv_pixel); pv_last = i; pv_cnt++;
      end
      if (res_we) begin
        if (wr_cnt >= exp_q.size() || res_addr !== RADDR_W'(wr_cnt) || res_wdata !== exp_q[wr_cnt])
          wr_bad++;
        last_waddr = int'(res_addr); wr_cnt++;
      end
      if (done) begin done_cnt++; done_idx = i; end
      if (i > 0 && !busy) begin fall_idx = i; last_re_val = int'(img_re); hung = 0; break; end
      conv_out_valid = 1'b0; conv_done = 1'b0; abort = 1'b0; start = 1'b0;
      if (i == rst_at) rst = 1'b1;
      else begin
        if (i == abort_at) abort = 1'b1;
        if (i == start_at) start = 1'b1;
        if (i == done_at)  conv_done = 1'b1;
        if (i >= 1 && i < N && i != abort_at && emitted < n_res && $urandom_range(0, 3) != 0) begin
          conv_out = OUT_W'($urandom);
          conv_out_valid = 1'b1;
          exp_q.push_back(conv_out);
          emitted++;
        end
      end
      @(posedge clk); #1;
    end
    conv_out_valid = 1'b0; conv_done = 1'b0; abort = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1; conv_out_valid = 1'b1; conv_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({busy, done, err_timeout, err_overflow, img_re, conv_start, conv_pixel_valid, res_we} !== 8'h00)
      begin n_bad++; $display("FAIL reset_strobes: got %b want 00000000", {busy, done, err_timeout, err_overflow, img_re, conv_start, conv_pixel_valid, res_we}); end
    n_vec++; if (result_count !== '0 || img_addr !== '0 || res_addr !== '0 || res_wdata !== '0)
      begin n_bad++; $display("FAIL reset_values: cnt=%0d img_addr=%0d res_addr=%0d wdata=%0h want all 0", result_count, img_addr, res_addr, res_wdata); end
    rst = 1'b0; start = 1'b0; abort = 1'b0; conv_out_valid = 1'b0; conv_done = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_normal_frame();
    int d;
    fill_mem(1'b1);
    d = $urandom_range(0, 15);
    run_frame(RES_DEPTH, N + d, -1, -1, -1);
    n_vec++; if (hung != 0) begin n_bad++; $display("FAIL normal_terminates: busy never fell"); end
    n_vec++; if (cs_cnt != 1 || cs_idx != 0) begin n_bad++; $display("FAIL normal_conv_start: count %0d at %0d want 1 at 0", cs_cnt, cs_idx); end
    n_vec++; if (pv_cnt != N || pv_gap != 0 || pv_first != 1) begin n_bad++; $display("FAIL normal_pix_valid: count %0d gaps %0d first %0d want %0d 0 1", pv_cnt, pv_gap, pv_first, N); end
    n_vec++; if (first_pix != 0 || last_pix != 'h0F || pix_bad != 0) begin n_bad++; $display("FAIL normal_pix_data: first %0h last %0h bad %0d want 0 f 0", first_pix, last_pix, pix_bad); end
    n_vec++; if (addr_bad != 0 || re_cnt != N) begin n_bad++; $display("FAIL normal_img_addr: bad %0d reads %0d want 0 %0d", addr_bad, re_cnt, N); end
    n_vec++; if (wr_cnt != RES_DEPTH || wr_bad != 0 || last_waddr != RES_DEPTH - 1) begin n_bad++; $display("FAIL normal_writes: count %0d bad %0d last %0d want %0d 0 %0d", wr_cnt, wr_bad, last_waddr, RES_DEPTH, RES_DEPTH - 1); end
    n_vec++; if (done_cnt != 1 || done_idx != N + d + 1) begin n_bad++; $display("FAIL normal_done: count %0d at %0d want 1 at %0d", done_cnt, done_idx, N + d + 1); end
    n_vec++; if (fall_idx != done_idx + 1) begin n_bad++; $display("FAIL normal_busy_fall: at %0d want %0d", fall_idx, done_idx + 1); end
    n_vec++; if (result_count !== (RADDR_W + 1)'(exp_count(emitted))) begin n_bad++; $display("FAIL normal_count: got %0d want %0d", result_count, exp_count(emitted)); end
    n_vec++; if (err_timeout !== 1'b0 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL normal_flags: tmo %b ovf %b want 0 0", err_timeout, err_overflow); end
  endtask

  task automatic test_timeout();
    int n_r;
    fill_mem(1'b0);
    n_r = $urandom_range(20, 150);
    run_frame(n_r, -1, -1, -1, -1);
    n_vec++; if (hung != 0) begin n_bad++; $display("FAIL timeout_terminates: busy never fell"); end
    n_vec++; if (done_cnt != 1 || done_idx != N + TIMEOUT) begin n_bad++; $display("FAIL timeout_done: count %0d at %0d want 1 at %0d", done_cnt, done_idx, N + TIMEOUT); end
    n_vec++; if (fall_idx != N + TIMEOUT + 1) begin n_bad++; $display("FAIL timeout_busy_fall: at %0d want %0d", fall_idx, N + TIMEOUT + 1); end
    n_vec++; if (err_timeout !== 1'b1 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL timeout_flags: tmo %b ovf %b want 1 0", err_timeout, err_overflow); end
    n_vec++; if (pix_bad != 0 || pv_cnt != N) begin n_bad++; $display("FAIL timeout_pixels: bad %0d count %0d want 0 %0d", pix_bad, pv_cnt, N); end
    n_vec++; if (result_count !== (RADDR_W + 1)'(exp_count(emitted)) || wr_bad != 0) begin n_bad++; $display("FAIL timeout_count: got %0d bad %0d want %0d 0", result_count, wr_bad, exp_count(emitted)); end
  endtask

  task automatic test_overflow();
    fill_mem(1'b0);
    run_frame(RES_DEPTH + 6, N + 2, -1, -1, -1);
    n_vec++; if (tmo0 !== 1'b0) begin n_bad++; $display("FAIL overflow_tmo_cleared: got %b want 0", tmo0); end
    n_vec++; if (wr_cnt != RES_DEPTH || wr_bad != 0 || last_waddr != RES_DEPTH - 1) begin n_bad++; $display("FAIL overflow_writes: count %0d bad %0d last %0d want %0d 0 %0d", wr_cnt, wr_bad, last_waddr, RES_DEPTH, RES_DEPTH - 1); end
    n_vec++; if (result_count !== (RADDR_W + 1)'(exp_count(emitted))) begin n_bad++; $display("FAIL overflow_count: got %0d want %0d", result_count, exp_count(emitted)); end
    n_vec++; if (err_overflow !== (emitted > RES_DEPTH)) begin n_bad++; $display("FAIL overflow_flag: got %b want %b", err_overflow, emitted > RES_DEPTH); end
    n_vec++; if (done_cnt != 1 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL overflow_done: count %0d tmo %b want 1 0", done_cnt, err_timeout); end
    run_frame(50, N, -1, -1, -1);
    n_vec++; if (ovf0 !== 1'b0 || cnt0 != 0) begin n_bad++; $display("FAIL overflow_cleared_on_start: ovf %b cnt %0d want 0 0", ovf0, cnt0); end
    n_vec++; if (err_overflow !== 1'b0 || result_count !== (RADDR_W + 1)'(exp_count(emitted))) begin n_bad++; $display("FAIL overflow_next_frame: ovf %b cnt %0d want 0 %0d", err_overflow, result_count, exp_count(emitted)); end
  endtask

  task automatic test_abort();
    int held;
    fill_mem(1'b0);
    run_frame(100, -1, 300, -1, -1);
    held = exp_count(emitted);
    n_vec++; if (hung != 0 || fall_idx != 301) begin n_bad++; $display("FAIL abort_idle: busy fell at %0d want 301", fall_idx); end
    n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    n_vec++; if (last_re_val != 0 || last_re_idx != 300) begin n_bad++; $display("FAIL abort_img_re: re %0d last read %0d want 0 300", last_re_val, last_re_idx); end
    n_vec++; if (pv_last != 301 || pv_cnt != 301 || pix_bad != 0) begin n_bad++; $display("FAIL abort_inflight: last %0d count %0d bad %0d want 301 301 0", pv_last, pv_cnt, pix_bad); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (result_count !== (RADDR_W + 1)'(held) || busy !== 1'b0) begin n_bad++; $display("FAIL abort_hold: cnt %0d busy %b want %0d 0", result_count, busy, held); end
    run_frame(RES_DEPTH, N + 1, -1, -1, -1);
    n_vec++; if (cs_cnt != 1 || cs_idx != 0 || addr_bad != 0 || re_cnt != N) begin n_bad++; $display("FAIL abort_restart: starts %0d at %0d addr_bad %0d reads %0d want 1 0 0 %0d", cs_cnt, cs_idx, addr_bad, re_cnt, N); end
    n_vec++; if (done_cnt != 1 || cnt0 != 0) begin n_bad++; $display("FAIL abort_restart_done: done %0d cnt0 %0d want 1 0", done_cnt, cnt0); end
  endtask

  task automatic test_back_to_back();
    fill_mem(1'b0);
    run_frame(120, 200, -1, 100, -1);
    n_vec++; if (cs_cnt != 1) begin n_bad++; $display("FAIL busy_start_ignored: conv_start count %0d want 1", cs_cnt); end
    n_vec++; if (pv_cnt != N || pv_gap != 0 || pix_bad != 0 || addr_bad != 0) begin n_bad++; $display("FAIL early_done_full_stream: count %0d gaps %0d bad %0d addr_bad %0d want %0d 0 0 0", pv_cnt, pv_gap, pix_bad, addr_bad, N); end
    n_vec++; if (done_idx - last_re_idx - 1 != 1 || done_idx != N + 1) begin n_bad++; $display("FAIL early_done_drain_len: drain %0d done at %0d want 1 at %0d", done_idx - last_re_idx - 1, done_idx, N + 1); end
    n_vec++; if (result_count !== (RADDR_W + 1)'(exp_count(emitted)) || wr_bad != 0 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL busy_start_count: cnt %0d bad %0d tmo %b want %0d 0 0", result_count, wr_bad, err_timeout, exp_count(emitted)); end
  endtask

  task automatic test_reset_drain();
    fill_mem(1'b0);
    run_frame(80, -1, -1, -1, N + 10);
    n_vec++; if (hung != 0 || fall_idx != N + 11 || done_cnt != 0) begin n_bad++; $display("FAIL rst_drain_idle: fell at %0d done %0d want %0d 0", fall_idx, done_cnt, N + 11); end
    n_vec++; if ({busy, done, err_timeout, err_overflow, img_re, conv_start, conv_pixel_valid, res_we} !== 8'h00)
      begin n_bad++; $display("FAIL rst_drain_strobes: got %b want 00000000", {busy, done, err_timeout, err_overflow, img_re, conv_start, conv_pixel_valid, res_we}); end
    n_vec++; if (result_count !== '0 || img_addr !== '0 || res_addr !== '0 || res_wdata !== '0)
      begin n_bad++; $display("FAIL rst_drain_values: cnt %0d img_addr %0d res_addr %0d wdata %0h want all 0", result_count, img_addr, res_addr, res_wdata); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_drain_stays_idle: busy %b done %b want 0 0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_timeout();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
